// File: rtl/mem_pkg.sv
// Shared defaults, state encoding and test-pattern generator for the memory BIST controller.
package mem_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 32;
  localparam int RD_TIMEOUT = 8;
  // Widest data word the pattern function supports.
  localparam int MAX_W      = 64;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_e;

  // Seed XOR the address replicated across the whole word.
  function automatic logic [MAX_W-1:0] pattern(input logic [MAX_W-1:0] seed,
                                               input logic [MAX_W-1:0] a,
                                               input int               aw);
    logic [MAX_W-1:0] rep;
    for (int i = 0; i < MAX_W; i++) begin
      rep[i] = a[i % aw];
    end
    return seed ^ rep;
  endfunction

endpackage

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST: write a seeded pattern to every location, read each back and
// compare, tracking failure count, lowest failing address and read timeouts.
module mem_bist_ctrl #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int DATA_W     = mem_pkg::DATA_W,
  parameter int RD_TIMEOUT = mem_pkg::RD_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              write_enable,
  output logic              read_enable,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              valid_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   fail_count,
  output logic [ADDR_W-1:0] first_fail_addr
);
  import mem_pkg::*;

  localparam int              TmoW    = $clog2(RD_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] AddrMax = '1;
  localparam logic [ADDR_W:0]   FailMax = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W:0]     fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0]   ffa_q, ffa_d;
  logic                pass_q, pass_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [DATA_W-1:0]   exp_data;
  logic                resolve, failed;

  assign exp_data = DATA_W'(pattern(MAX_W'(seed_q), MAX_W'(addr_q), ADDR_W));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    seed_d       = seed_q;
    fail_cnt_d   = fail_cnt_q;
    ffa_d        = ffa_q;
    pass_d       = pass_q;
    tmo_d        = tmo_q;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    data_in      = '0;
    busy         = 1'b0;
    done         = 1'b0;
    resolve      = 1'b0;
    failed       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          seed_d     = seed;
          fail_cnt_d = '0;
          ffa_d      = '0;
          pass_d     = 1'b0;
          addr_d     = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        busy         = 1'b1;
        write_enable = 1'b1;
        data_in      = exp_data;
        addr_d       = addr_q + ADDR_W'(1);
        if (addr_q == AddrMax) state_d = READ;
      end
      READ: begin
        busy        = 1'b1;
        read_enable = 1'b1;
        tmo_d       = TmoW'(1);
        // A response in the strobe cycle is a zero-latency memory.
        if (valid_out) begin
          resolve = 1'b1;
          failed  = (data_out != exp_data);
        end else if (RD_TIMEOUT <= 1) begin
          resolve = 1'b1;
          failed  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        // tmo_q counts cycles elapsed since the strobe, strobe cycle included.
        if (valid_out) begin
          resolve = 1'b1;
          failed  = (data_out != exp_data);
        end else if ((int'(tmo_q) + 1) >= RD_TIMEOUT) begin
          resolve = 1'b1;
          failed  = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        pass_d  = (fail_cnt_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resolve) begin
      if (failed) begin
        if (fail_cnt_q == '0) ffa_d = addr_q;
        if (fail_cnt_q != FailMax) fail_cnt_d = fail_cnt_q + (ADDR_W + 1)'(1);
      end
      if (addr_q == AddrMax) begin
        state_d = DONE;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = READ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      seed_q     <= '0;
      fail_cnt_q <= '0;
      ffa_q      <= '0;
      pass_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      seed_q     <= seed_d;
      fail_cnt_q <= fail_cnt_d;
      ffa_q      <= ffa_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
    end
  end

  assign addr            = addr_q;
  assign pass            = pass_q;
  assign fail_count      = fail_cnt_q;
  assign first_fail_addr = ffa_q;

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, 4, memory address width.
REQ-002 Parameter DATA_W, 32, memory data width.
REQ-003 Parameter RD_TIMEOUT, 8, max cycles to wait for valid_out after a read request.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a test run when idle.
REQ-007 seed  in  DATA_W  pattern seed, sampled on accepted start.
REQ-008 write_enable  out  1  memory write strobe.
REQ-009 read_enable  out  1  memory read strobe.
REQ-010 addr  out  ADDR_W  memory address.
REQ-011 data_in  out  DATA_W  memory write data.
REQ-012 data_out  in  DATA_W  memory read data.
REQ-013 valid_out  in  1  qualifies data_out.
REQ-014 busy  out  1  run in progress.
REQ-015 done  out  1  one-cycle pulse at end of run.
REQ-016 pass  out  1  last run had zero failures; valid from done until next start.
REQ-017 fail_count  out  ADDR_W+1  failing locations in last run.
REQ-018 first_fail_addr  out  ADDR_W  lowest failing address; 0 if none.

Function
REQ-019 States: IDLE, WRITE, READ, WAIT, DONE.
REQ-020 IDLE: start=1 -> latch seed, clear fail_count/first_fail_addr/pass, addr=0, go WRITE; start ignored in all other states.
REQ-021 Pattern: expected(a) = seed XOR (address a replicated to fill DATA_W); for defaults, 8 copies of the 4-bit address.
REQ-022 WRITE: write_enable=1, data_in=expected(addr), one location per cycle; after addr 2^ADDR_W-1, addr wraps to 0, go READ.
REQ-023 READ: read_enable=1 for exactly one cycle at addr, go WAIT; write_enable and read_enable never both high.
REQ-024 WAIT: read_enable=0, addr held; valid_out=1 -> compare data_out to expected(addr); mismatch counts as failure.
REQ-025 WAIT: RD_TIMEOUT cycles with no valid_out (counted from READ cycle) -> failure, no compare.
REQ-026 valid_out=1 in the same cycle as the READ strobe is accepted as the response (zero-latency memory).
REQ-027 valid_out while not in READ/WAIT is ignored.
REQ-028 On failure: fail_count += 1 (saturates at 2^ADDR_W); first_fail_addr set only on first failure of the run.
REQ-029 After WAIT resolves: addr < max -> addr+1, go READ; addr = max -> go DONE.
REQ-030 DONE: done=1 for one cycle, pass=(fail_count==0), go IDLE; results held until next accepted start.
REQ-031 busy=1 in WRITE, READ, WAIT; 0 in IDLE and DONE.
REQ-032 Full run with 1-cycle memory latency: 16 write + 16x2 read/wait + 1 done = 49 cycles start-to-done.

Reset
REQ-033 rst=1 at any clock edge, including mid-run: state=IDLE, write_enable=0, read_enable=0, addr=0, data_in=0, busy=0, done=0, pass=0, fail_count=0, first_fail_addr=0.
REQ-034 Aborted run produces no done pulse; rst has priority over start.

Structure
REQ-035 Shared package mem_pkg holds ADDR_W, DATA_W, RD_TIMEOUT defaults and the state enum typedef.
REQ-036 Pattern generator is a combinational function in mem_pkg; no sub-module; single flat module.

Verification
REQ-037 Good memory (1-cycle latency), seed=32'h0000_0000 -> addr 5 written with 32'h5555_5555; done after 49 cycles; pass=1, fail_count=0.
REQ-038 Memory with bit 0 stuck-at-1 at addr 3 and addr 9, seed=32'hA5A5_A5A5 -> pass=0, fail_count=2, first_fail_addr=3.
REQ-039 Memory never asserts valid_out at addr 7 -> 8-cycle timeout there, run completes, fail_count=1, first_fail_addr=7.
REQ-040 rst pulsed during WRITE at addr 6 -> all outputs at reset values next cycle, no done; new start runs clean to pass=1.
REQ-041 start pulsed while busy -> ignored, seed unchanged, single done; zero-latency memory -> run still passes.
